system_cpu_cpu_debug_ocimem_ctrl: RTL and testbench

SYSTEM_CPU_CPU_DEBUG_OCIMEM_CTRL -- requirements
Module: system_cpu_cpu_debug_ocimem_ctrl

---
 rtl/system_cpu_cpu_debug_ocimem_ctrl_pkg.sv | 45 ++++
 rtl/system_cpu_cpu_debug_ocimem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_system_cpu_cpu_debug_ocimem_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/system_cpu_cpu_debug_ocimem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : system_cpu_cpu_debug_ocimem_ctrl_pkg
// Description : Shared constants and types for the cpu debug on-chip memory
//               controller: RAM geometry, jdo field positions, FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package system_cpu_cpu_debug_ocimem_ctrl_pkg;

    // Debug RAM geometry (word addressed)
    localparam int RAM_DEPTH = 256;
    localparam int RAM_WIDTH = 32;
    localparam int ADDR_W    = $clog2(RAM_DEPTH);
    localparam int BE_W      = RAM_WIDTH / 8;

    // JTAG data word layout
    localparam int JDO_W           = 38;
    localparam int JDO_ADDR_LSB    = 18;
    localparam int JDO_ADDR_MSB    = 25;
    localparam int JDO_DATA_LSB    = 3;
    localparam int JDO_DATA_MSB    = 34;
    localparam int JDO_READ_BIT    = 35;
    localparam int JDO_CLR_OVR_BIT = 36;

    // Arbiter / sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        AV_RDW = 2'd1,
        AV_ACK = 2'd2,
        JT_RDW = 2'd3
    } ocimem_state_t;

    // Requester most recently served by the arbiter
    typedef enum logic {
        GRANT_AV = 1'b0,
        GRANT_JT = 1'b1
    } grant_t;

    // Post-access JTAG address advance; wraps naturally at the top of the RAM
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        return addr + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/system_cpu_cpu_debug_ocimem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : system_cpu_cpu_debug_ocimem_ctrl
// Description : Arbitrates an external 256x32 debug RAM between an Avalon
//               slave port and a single-entry JTAG command queue.
// Revision    : 1.0 - initial release
// ============================================================================
module system_cpu_cpu_debug_ocimem_ctrl
    import system_cpu_cpu_debug_ocimem_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [JDO_W-1:0]     jdo,
    input  logic                 take_action_ocimem_a,
    input  logic                 take_action_ocimem_b,
    input  logic                 take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0]    av_address,
    input  logic                 av_read,
    input  logic                 av_write,
    input  logic [RAM_WIDTH-1:0] av_writedata,
    input  logic [BE_W-1:0]      av_byteenable,
    output logic [RAM_WIDTH-1:0] av_readdata,
    output logic                 av_waitrequest,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [RAM_WIDTH-1:0] ram_wdata,
    output logic [BE_W-1:0]      ram_be,
    output logic                 ram_wren,
    output logic                 ram_rden,
    input  logic [RAM_WIDTH-1:0] ram_rdata,
    output logic [RAM_WIDTH-1:0] MonDReg,
    output logic                 monitor_ready,
    output logic                 jtag_overrun
);

    ocimem_state_t       state;
    ocimem_state_t       state_next;
    grant_t              last_grant;

    logic [ADDR_W-1:0]   jtag_addr;
    logic                jtag_pend;
    logic                jtag_pend_wr;

    logic                av_req;
    logic                grant_jt;
    logic                grant_av;
    logic                jt_wr_done;
    logic                jt_rd_done;
    logic                jtag_strobe;
    logic                jdo_unused;

    // Bits of jdo outside the decoded fields carry nothing for this block
    assign jdo_unused = ^{jdo[JDO_W-1], jdo[JDO_DATA_LSB-1:0]};

    assign av_req      = av_read | av_write;
    assign jtag_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    // Grants are suppressed while reset is held so no RAM write can slip in
    assign grant_jt = reset_n && (state == IDLE) && jtag_pend &&
                      ((last_grant == GRANT_AV) || !av_req);
    assign grant_av = reset_n && (state == IDLE) && !grant_jt && av_req;

    assign jt_wr_done = grant_jt && jtag_pend_wr;
    assign jt_rd_done = (state == JT_RDW);

    // Next-state decode and RAM/Avalon strobes; RAM bus idles at zero
    always_comb begin
        state_next     = state;
        av_waitrequest = 1'b1;
        ram_addr       = '0;
        ram_wdata      = '0;
        ram_be         = '0;
        ram_wren       = 1'b0;
        ram_rden       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_jt) begin
                    ram_addr = jtag_addr;
                    ram_be   = '1;
                    if (jtag_pend_wr) begin
                        ram_wren  = 1'b1;
                        ram_wdata = MonDReg;
                    end else begin
                        ram_rden   = 1'b1;
                        state_next = JT_RDW;
                    end
                end else if (grant_av) begin
                    ram_addr = av_address;
                    ram_be   = av_byteenable;
                    if (av_write) begin
                        ram_wren   = 1'b1;
                        ram_wdata  = av_writedata;
                        state_next = AV_ACK;
                    end else begin
                        ram_rden   = 1'b1;
                        state_next = AV_RDW;
                    end
                end
            end
            AV_RDW: begin
                state_next = AV_ACK;
            end
            AV_ACK: begin
                av_waitrequest = 1'b0;
                state_next     = IDLE;
            end
            JT_RDW: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, round-robin memory and Avalon read-data capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= GRANT_AV;
            av_readdata <= '0;
        end else begin
            state <= state_next;
            // Remembering the served requester makes simultaneous requests alternate
            if (grant_jt) begin
                last_grant <= GRANT_JT;
            end else if (grant_av) begin
                last_grant <= GRANT_AV;
            end
            if (state == AV_RDW) begin
                av_readdata <= ram_rdata;
            end
        end
    end

    // JTAG command queue: strobe decode, completion, overrun tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_addr     <= '0;
            jtag_pend     <= 1'b0;
            jtag_pend_wr  <= 1'b0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            jtag_overrun  <= 1'b0;
        end else begin
            if (jt_wr_done || jt_rd_done) begin
                jtag_addr     <= next_addr(jtag_addr);
                monitor_ready <= 1'b1;
                jtag_pend     <= 1'b0;
            end
            if (jt_rd_done) begin
                MonDReg <= ram_rdata;
            end
            // Completion only happens with jtag_pend set, so any strobe in the
            // same cycle lands in the overrun branch and never collides with it
            if (jtag_strobe) begin
                if (jtag_pend) begin
                    jtag_overrun <= 1'b1;
                end else if (take_action_ocimem_a) begin
                    jtag_addr <= jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
                    if (jdo[JDO_CLR_OVR_BIT]) begin
                        jtag_overrun <= 1'b0;
                    end
                    if (jdo[JDO_READ_BIT]) begin
                        jtag_pend     <= 1'b1;
                        jtag_pend_wr  <= 1'b0;
                        monitor_ready <= 1'b0;
                    end
                end else if (take_action_ocimem_b) begin
                    MonDReg       <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                    jtag_pend     <= 1'b1;
                    jtag_pend_wr  <= 1'b1;
                    monitor_ready <= 1'b0;
                end else begin
                    jtag_pend     <= 1'b1;
                    jtag_pend_wr  <= 1'b0;
                    monitor_ready <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_system_cpu_cpu_debug_ocimem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_system_cpu_cpu_debug_ocimem_ctrl
// Description : Directed self-checking bench for the debug RAM controller,
//               with a behavioural model of the external RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_system_cpu_cpu_debug_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [7:0]  av_address;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_wren;
    logic        ram_rden;
    logic [31:0] ram_rdata = '0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        jtag_overrun;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:255];
    int          wr_count = 0;
    bit          both_seen = 1'b0;

    system_cpu_cpu_debug_ocimem_ctrl dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_byteenable           (av_byteenable),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_be                  (ram_be),
        .ram_wren                (ram_wren),
        .ram_rden                (ram_rden),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .jtag_overrun            (jtag_overrun)
    );

    always #5 clk = ~clk;

    // External RAM model: byte-enabled write, one-cycle registered read
    always @(posedge clk) begin
        if (ram_wren && ram_rden) both_seen = 1'b1;
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            wr_count++;
        end
        if (ram_rden) ram_rdata <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] d;
        d        = '0;
        d[25:18] = a;
        d[35]    = rd;
        d[36]    = clr;
        return d;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        logic [37:0] d;
        d       = '0;
        d[34:3] = data;
        return d;
    endfunction

    // One-cycle JTAG strobe; entered and left at a drive point
    task automatic jtag(input logic sa, input logic sb, input logic sn, input logic [37:0] d);
        jdo                     = d;
        take_action_ocimem_a    = sa;
        take_action_ocimem_b    = sb;
        take_no_action_ocimem_a = sn;
        step();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    // Avalon transfer; lat counts cycles from request until waitrequest low
    task automatic av_access(input logic wr, input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] be, output logic [31:0] rd, output int lat);
        av_address    = a;
        av_writedata  = d;
        av_byteenable = be;
        av_write      = wr;
        av_read       = !wr;
        lat           = 0;
        rd            = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (!av_waitrequest) begin
                rd = av_readdata;
                break;
            end
        end
        step();
        av_read  = 1'b0;
        av_write = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;
    int          wcount;
    int          av_grant_lat;
    int          av_start, jt_start, max_av_wait, max_jt_wait, n_av, n_jt, alt_bad, ngr;
    bit          last_who, who, ready_s, strobe_prev;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset_n                 = 1'b0;
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        av_address              = '0;
        av_read                 = 1'b0;
        av_write                = 1'b0;
        av_writedata            = '0;
        av_byteenable           = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_waitrequest", av_waitrequest, 1);
        check("rst_monitor_ready", monitor_ready, 1);
        check("rst_MonDReg", MonDReg, 0);
        check("rst_readdata", av_readdata, 0);
        check("rst_overrun", jtag_overrun, 0);
        check("rst_wren_rden", {ram_wren, ram_rden}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_ram_bus_zero", {ram_addr, ram_be, ram_wdata}, 0);
        step();

        // Avalon write then read, latency 2 and 3
        av_access(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd, lat);
        check("av_wr_latency", lat, 2);
        check("av_wr_ram", mem[8'h10], 32'hDEADBEEF);
        av_access(1'b0, 8'h10, 32'h0, 4'hF, rd, lat);
        check("av_rd_latency", lat, 3);
        check("av_rd_data", rd, 32'hDEADBEEF);
        // Partial byte enables
        av_access(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, rd, lat);
        av_access(1'b0, 8'h20, 32'h0, 4'hF, rd, lat);
        check("av_be_partial", rd, 32'h00BB00DD);

        // JTAG write at top address, address wraps to 0
        jtag(1'b1, 1'b0, 1'b0, mk_a(8'hFF, 1'b0, 1'b0));
        jtag(1'b0, 1'b1, 1'b0, mk_b(32'h12345678));
        @(negedge clk);
        check("jt_busy_ready", monitor_ready, 0);
        check("jt_wr_bus", {ram_wren, ram_addr, ram_be}, {1'b1, 8'hFF, 4'hF});
        step();
        @(negedge clk);
        check("jt_wr_ready", monitor_ready, 1);
        check("jt_wr_ram_ff", mem[8'hFF], 32'h12345678);
        check("jt_wr_MonDReg", MonDReg, 32'h12345678);
        step();
        jtag(1'b0, 1'b1, 1'b0, mk_b(32'hCAFEF00D));
        step(); step();
        check("jt_addr_wrap", mem[8'h00], 32'hCAFEF00D);

        // Overrun: second write strobe while the first is still pending
        jtag(1'b0, 1'b1, 1'b0, mk_b(32'h11111111));
        jtag(1'b0, 1'b1, 1'b0, mk_b(32'h22222222));
        @(negedge clk);
        check("ovr_set", jtag_overrun, 1);
        check("ovr_MonDReg_kept", MonDReg, 32'h11111111);
        check("ovr_first_written", mem[8'h01], 32'h11111111);
        step(); step(); step();
        check("ovr_second_dropped", mem[8'h02], 32'h0);
        jtag(1'b1, 1'b0, 1'b0, mk_a(8'h40, 1'b0, 1'b1));
        @(negedge clk);
        check("ovr_clear", jtag_overrun, 0);
        step();

        // Reset dropped during AV_RDW
        av_address = 8'h10;
        av_read    = 1'b1;
        step();
        wcount  = wr_count;
        reset_n = 1'b0;
        av_read = 1'b0;
        #1;
        check("mid_rst_waitrequest", av_waitrequest, 1);
        check("mid_rst_readdata", av_readdata, 0);
        check("mid_rst_MonDReg", MonDReg, 0);
        check("mid_rst_rden", ram_rden, 0);
        step(); step();
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_no_write", wr_count, wcount);
        check("mid_rst_readdata_held", av_readdata, 0);
        check("mid_rst_ready", monitor_ready, 1);
        step();

        // JTAG read pending alongside Avalon read: JTAG first after reset
        jtag(1'b1, 1'b0, 1'b0, mk_a(8'hFF, 1'b1, 1'b0));
        av_address = 8'h10;
        av_read    = 1'b1;
        @(negedge clk);
        check("arb_jt_first", {ram_rden, ram_addr}, {1'b1, 8'hFF});
        lat          = 1;
        av_grant_lat = 0;
        rd           = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            lat++;
            if (ram_rden && ram_addr == 8'h10 && av_grant_lat == 0) av_grant_lat = lat;
            if (!av_waitrequest) begin
                rd = av_readdata;
                break;
            end
        end
        check("arb_av_grant_cycle", av_grant_lat, 3);
        check("arb_av_latency", lat, 5);
        check("arb_av_data", rd, 32'hDEADBEEF);
        check("arb_jt_data", MonDReg, 32'h12345678);
        step();
        av_read = 1'b0;
        step();

        // Continuous Avalon reads with repeated JTAG reads
        @(negedge clk);
        ready_s     = monitor_ready;
        strobe_prev = 1'b0;
        av_start    = 0;
        jt_start    = 0;
        max_av_wait = 0;
        max_jt_wait = 0;
        n_av        = 0;
        n_jt        = 0;
        alt_bad     = 0;
        ngr         = 0;
        last_who    = 1'b0;
        step();
        for (int cyc = 0; cyc < 40; cyc++) begin
            av_address = 8'h10;
            av_read    = 1'b1;
            take_no_action_ocimem_a = ready_s && !strobe_prev;
            if (take_no_action_ocimem_a) jt_start = cyc;
            strobe_prev = take_no_action_ocimem_a;
            @(negedge clk);
            if (ram_rden) begin
                who = (ram_addr != 8'h10);
                if (ngr > 0 && who == last_who) alt_bad++;
                last_who = who;
                ngr++;
                if (who) begin
                    n_jt++;
                    if (cyc - jt_start > max_jt_wait) max_jt_wait = cyc - jt_start;
                end else begin
                    n_av++;
                    if (cyc - av_start > max_av_wait) max_av_wait = cyc - av_start;
                end
            end
            if (!av_waitrequest) av_start = cyc + 1;
            ready_s = monitor_ready;
            step();
        end
        take_no_action_ocimem_a = 1'b0;
        av_read = 1'b0;
        check("mix_alternate", alt_bad, 0);
        check("mix_av_wait_le4", (max_av_wait <= 4), 1);
        check("mix_jt_wait_le4", (max_jt_wait <= 4), 1);
        check("mix_jt_grants", (n_jt >= 4), 1);
        check("mix_av_grants", (n_av >= 4), 1);
        step(); step();
        check("rw_exclusive", both_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
